rdma_int_msg_gen: RTL and testbench

Consumer side of the MSI-X vector table lookup path. Accepts interrupt requests (vector number) from the EQ engine and issues a table lookup to the MSI-X table block. It receives the 128-bit entry and emits a 32-bit posted memory-write request to the PCIe requester.
- Vector-control mask and function-level mask are honoured.
- Masked interrupts are held in a Pending Bit Array (PBA) and replayed by a periodic rescan.

---
 rtl/rdma_int_msg_gen_pkg.sv | 25 ++
 rtl/rdma_int_pba_pick.sv | 28 ++
 rtl/rdma_int_msg_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_rdma_int_msg_gen.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdma_int_msg_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rdma_int_msg_gen_pkg
// Brief    : Shared definitions for the MSI-X message generator: MSI-X table
//            entry field offsets and the controller state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package rdma_int_msg_gen_pkg;

    // Field offsets inside a 128-bit MSI-X table entry
    localparam int ENT_ADDR_LO_LSB = 0;    // dw0 : message address [31:0]
    localparam int ENT_ADDR_HI_LSB = 32;   // dw1 : message address [63:32]
    localparam int ENT_DATA_LSB    = 64;   // dw2 : message data
    localparam int ENT_MASK_BIT    = 96;   // dw3 bit 0 : per-vector mask

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOOKUP   = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_ISSUE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rdma_int_pba_pick.sv
`default_nettype none
// ============================================================================
// Module   : rdma_int_pba_pick
// Brief    : Combinational lowest-set-bit priority encoder over the pending
//            bit array; returns the index and an any-bit-set flag.
// Revision : 1.0 - initial release
// ============================================================================
module rdma_int_pba_pick #(
    parameter int IDX_W = 6
) (
    input  logic [2**IDX_W-1:0] vec,
    output logic [IDX_W-1:0]    idx,
    output logic                any
);

    // Scan from the top down so the lowest set bit is the last one written
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = 2**IDX_W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rdma_int_msg_gen.sv
`default_nettype none
// ============================================================================
// Module   : rdma_int_msg_gen
// Brief    : Turns EQ interrupt requests into MSI-X posted writes via an
//            MSI-X table lookup; masked vectors are parked in the PBA and
//            replayed by a periodic rescan.
//            Optional macro RDMA_INT_MSG_STAT_EN adds sent/pended/dropped
//            statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module rdma_int_msg_gen
    import rdma_int_msg_gen_pkg::*;
#(
    parameter int MSIX_NUM_LOG   = 6,
    parameter int RETRY_INTERVAL = 256,
    parameter int RETRY_CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         eq_int_req_valid,
    input  logic [MSIX_NUM_LOG-1:0]      eq_int_req_num,
    output logic                         eq_int_req_ready,
    output logic                         tbl_req_valid,
    output logic [MSIX_NUM_LOG-1:0]      tbl_req_num,
    input  logic                         tbl_req_ready,
    input  logic                         tbl_rsp_valid,
    input  logic [127:0]                 tbl_rsp_data,
    output logic                         tbl_rsp_ready,
    output logic                         msix_wr_valid,
    output logic [63:0]                  msix_wr_addr,
    output logic [31:0]                  msix_wr_data,
    input  logic                         msix_wr_ready,
    input  logic                         cfg_msix_en,
    input  logic                         cfg_func_mask,
    output logic [2**MSIX_NUM_LOG-1:0]   pba,
    output logic                         addr_err
`ifdef RDMA_INT_MSG_STAT_EN
    ,
    output logic [31:0]                  stat_sent,
    output logic [31:0]                  stat_pended,
    output logic [31:0]                  stat_dropped
`endif
);

    localparam int                     NV   = 2**MSIX_NUM_LOG;
    localparam logic [RETRY_CNT_W-1:0] TERM = RETRY_CNT_W'(RETRY_INTERVAL - 1);

    state_t                  state, state_nx;
    logic [MSIX_NUM_LOG-1:0] num_q;
    logic                    retry_q;
    logic [NV-1:0]           pba_q;
    logic                    addr_err_q;
    logic [RETRY_CNT_W-1:0]  timer_q;
    logic [63:0]             wr_addr_q;
    logic [31:0]             wr_data_q;

    logic [MSIX_NUM_LOG-1:0] pick_idx;
    logic                    pick_any;

    rdma_int_pba_pick #(.IDX_W(MSIX_NUM_LOG)) u_pick (
        .vec (pba_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Event decode shared by the FSM and the datapath
    logic eq_acc, eq_go, eq_pend, eq_drop, timer_term, retry_go;
    logic rsp_hs, rsp_mask, rsp_bad, set_rsp, clr_rsp;
    always_comb begin
        eq_acc     = eq_int_req_valid && (state == ST_IDLE);
        eq_go      = eq_acc && cfg_msix_en && !cfg_func_mask;
        eq_pend    = eq_acc && cfg_msix_en && cfg_func_mask;
        eq_drop    = eq_acc && !cfg_msix_en;
        timer_term = (timer_q == TERM);
        // A concurrent EQ request always wins over the rescan
        retry_go   = (state == ST_IDLE) && !eq_int_req_valid && pick_any &&
                     timer_term && cfg_msix_en && !cfg_func_mask;
        rsp_hs     = (state == ST_WAIT_RSP) && tbl_rsp_valid;
        rsp_mask   = tbl_rsp_data[ENT_MASK_BIT];
        rsp_bad    = |tbl_rsp_data[ENT_ADDR_LO_LSB +: 2];
        // A masked entry fetched on a rescan is already pending in the PBA
        set_rsp    = rsp_hs && rsp_mask && !retry_q;
        clr_rsp    = rsp_hs && !rsp_mask;
    end

    // Next-state and handshake outputs
    always_comb begin
        state_nx         = state;
        eq_int_req_ready = 1'b0;
        tbl_req_valid    = 1'b0;
        tbl_rsp_ready    = 1'b0;
        msix_wr_valid    = 1'b0;
        case (state)
            ST_IDLE: begin
                // Held low while reset is asserted so every output reads 0
                eq_int_req_ready = rst_n;
                if (eq_go || retry_go) begin
                    state_nx = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                tbl_req_valid = 1'b1;
                if (tbl_req_ready) begin
                    state_nx = ST_WAIT_RSP;
                end
            end
            ST_WAIT_RSP: begin
                tbl_rsp_ready = 1'b1;
                if (tbl_rsp_valid) begin
                    state_nx = (rsp_mask || rsp_bad) ? ST_IDLE : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                msix_wr_valid = 1'b1;
                if (msix_wr_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Vector latch, retry flag and rescan timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q   <= '0;
            retry_q <= 1'b0;
            timer_q <= '0;
        end else begin
            if (eq_go) begin
                num_q   <= eq_int_req_num;
                retry_q <= 1'b0;
            end else if (retry_go) begin
                num_q   <= pick_idx;
                retry_q <= 1'b1;
            end
            if (state == ST_IDLE) begin
                if (!pick_any || retry_go) begin
                    timer_q <= '0;
                end else if (!timer_term) begin
                    timer_q <= timer_q + RETRY_CNT_W'(1);
                end
            end
        end
    end

    // Pending bit array, sticky address error and the captured message
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pba_q      <= '0;
            addr_err_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            if (eq_pend) begin
                pba_q[eq_int_req_num] <= 1'b1;
            end
            if (set_rsp) begin
                pba_q[num_q] <= 1'b1;
            end
            if (clr_rsp) begin
                pba_q[num_q] <= 1'b0;
            end
            if (clr_rsp && rsp_bad) begin
                addr_err_q <= 1'b1;
            end
            if (clr_rsp && !rsp_bad) begin
                wr_addr_q <= {tbl_rsp_data[ENT_ADDR_HI_LSB +: 32],
                              tbl_rsp_data[ENT_ADDR_LO_LSB +: 32]};
                wr_data_q <= tbl_rsp_data[ENT_DATA_LSB +: 32];
            end
        end
    end

    assign tbl_req_num  = num_q;
    assign msix_wr_addr = wr_addr_q;
    assign msix_wr_data = wr_data_q;
    assign pba          = pba_q;
    assign addr_err     = addr_err_q;

`ifdef RDMA_INT_MSG_STAT_EN
    logic pend_new;
    always_comb begin
        pend_new = (eq_pend && !pba_q[eq_int_req_num]) ||
                   (set_rsp && !pba_q[num_q]);
    end

    // Wrapping event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_sent    <= '0;
            stat_pended  <= '0;
            stat_dropped <= '0;
        end else begin
            if (msix_wr_valid && msix_wr_ready) begin
                stat_sent <= stat_sent + 32'd1;
            end
            if (pend_new) begin
                stat_pended <= stat_pended + 32'd1;
            end
            if (eq_drop || (clr_rsp && rsp_bad)) begin
                stat_dropped <= stat_dropped + 32'd1;
            end
        end
    end
`else
    logic unused_drop;
    assign unused_drop = eq_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rdma_int_msg_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_rdma_int_msg_gen
// Brief    : Directed testbench for rdma_int_msg_gen with a transaction-level
//            reference model, a table responder and per-cycle output checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rdma_int_msg_gen;

    localparam int NL = 6;
    localparam int NV = 64;
    localparam int RI = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          eq_int_req_valid = 1'b0;
    logic [NL-1:0] eq_int_req_num = '0;
    logic          eq_int_req_ready;
    logic          tbl_req_valid;
    logic [NL-1:0] tbl_req_num;
    logic          tbl_req_ready = 1'b1;
    logic          tbl_rsp_valid = 1'b0;
    logic [127:0]  tbl_rsp_data = '0;
    logic          tbl_rsp_ready;
    logic          msix_wr_valid;
    logic [63:0]   msix_wr_addr;
    logic [31:0]   msix_wr_data;
    logic          msix_wr_ready = 1'b1;
    logic          cfg_msix_en = 1'b0;
    logic          cfg_func_mask = 1'b0;
    logic [NV-1:0] pba;
    logic          addr_err;
`ifdef RDMA_INT_MSG_STAT_EN
    logic [31:0]   stat_sent, stat_pended, stat_dropped;
`endif

    always #5 clk = ~clk;

    rdma_int_msg_gen #(
        .MSIX_NUM_LOG   (NL),
        .RETRY_INTERVAL (RI),
        .RETRY_CNT_W    (16)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .eq_int_req_valid (eq_int_req_valid),
        .eq_int_req_num   (eq_int_req_num),
        .eq_int_req_ready (eq_int_req_ready),
        .tbl_req_valid    (tbl_req_valid),
        .tbl_req_num      (tbl_req_num),
        .tbl_req_ready    (tbl_req_ready),
        .tbl_rsp_valid    (tbl_rsp_valid),
        .tbl_rsp_data     (tbl_rsp_data),
        .tbl_rsp_ready    (tbl_rsp_ready),
        .msix_wr_valid    (msix_wr_valid),
        .msix_wr_addr     (msix_wr_addr),
        .msix_wr_data     (msix_wr_data),
        .msix_wr_ready    (msix_wr_ready),
        .cfg_msix_en      (cfg_msix_en),
        .cfg_func_mask    (cfg_func_mask),
        .pba              (pba),
        .addr_err         (addr_err)
`ifdef RDMA_INT_MSG_STAT_EN
        ,
        .stat_sent        (stat_sent),
        .stat_pended      (stat_pended),
        .stat_dropped     (stat_dropped)
`endif
    );

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int lowest_set(input logic [NV-1:0] v);
        for (int i = 0; i < NV; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // MSI-X table contents served by the responder
    logic [127:0] tbl [NV];

    // ------------------------------------------------------------------
    // Reference model state (transaction level)
    // ------------------------------------------------------------------
    logic [NV-1:0] m_pba = '0;
    logic          m_err = 1'b0;
    int            m_cur = 0;
    bit            m_in_op = 0;
    bit            m_eq_pending = 0;
    int            m_eq_num = 0;
    logic [95:0]   exp_wr_q[$];
    logic [31:0]   m_sent = 0, m_pended = 0, m_dropped = 0;
    int            n_lookups = 0;
    int            n_writes = 0;
    int            lk_hist[$];
    logic [63:0]   last_wr_addr = '0;
    logic [31:0]   last_wr_data = '0;
    int            rsp_cyc = 0;
    int            wr_first_cyc = 0;
    bit            prev_wr_valid = 0;

    // Compare process: checks outputs against the model, then advances the
    // model with the handshakes that complete at the coming rising edge.
    always @(negedge clk) begin
        logic [127:0] e;
        if (!rst_n) begin
            m_pba = '0; m_err = 0; m_in_op = 0; m_eq_pending = 0;
            exp_wr_q.delete();
            m_sent = 0; m_pended = 0; m_dropped = 0;
            prev_wr_valid = 0;
        end else begin
            chk("pba", pba, m_pba);
            chk("addr_err", addr_err, m_err);
`ifdef RDMA_INT_MSG_STAT_EN
            chk("stat_sent", stat_sent, m_sent);
            chk("stat_pended", stat_pended, m_pended);
            chk("stat_dropped", stat_dropped, m_dropped);
`endif
            if (m_in_op || m_eq_pending || exp_wr_q.size() != 0)
                chk("ready_while_busy", eq_int_req_ready, 1'b0);

            if (tbl_req_valid) begin
                if (!m_in_op) begin
                    if (m_eq_pending) begin
                        m_cur = m_eq_num;
                        m_eq_pending = 0;
                    end else begin
                        m_cur = lowest_set(m_pba);
                        if (m_cur < 0) begin
                            chk("unexpected_lookup", tbl_req_valid, 1'b0);
                            m_cur = 0;
                        end
                    end
                    m_in_op = 1;
                    n_lookups++;
                    lk_hist.push_back(m_cur);
                end
                chk("tbl_req_num", tbl_req_num, m_cur[NL-1:0]);
            end

            if (tbl_rsp_valid && tbl_rsp_ready) begin
                rsp_cyc = cyc;
                e = tbl[m_cur];
                if (e[96]) begin
                    if (!m_pba[m_cur]) m_pended++;
                    m_pba[m_cur] = 1'b1;
                    m_in_op = 0;
                end else if (e[1:0] != 2'b00) begin
                    m_err = 1'b1;
                    m_pba[m_cur] = 1'b0;
                    m_dropped++;
                    m_in_op = 0;
                end else begin
                    m_pba[m_cur] = 1'b0;
                    exp_wr_q.push_back({e[63:0], e[95:64]});
                end
            end

            if (msix_wr_valid && !prev_wr_valid) wr_first_cyc = cyc;
            prev_wr_valid = msix_wr_valid;
            if (msix_wr_valid) begin
                if (exp_wr_q.size() == 0) begin
                    chk("unexpected_write", msix_wr_valid, 1'b0);
                end else begin
                    chk("wr_addr", msix_wr_addr, exp_wr_q[0][95:32]);
                    chk("wr_data", msix_wr_data, exp_wr_q[0][31:0]);
                    if (msix_wr_ready) begin
                        last_wr_addr = msix_wr_addr;
                        last_wr_data = msix_wr_data;
                        void'(exp_wr_q.pop_front());
                        m_in_op = 0;
                        m_sent++;
                        n_writes++;
                    end
                end
            end

            if (eq_int_req_valid && eq_int_req_ready) begin
                if (!cfg_msix_en) begin
                    m_dropped++;
                end else if (cfg_func_mask) begin
                    if (!m_pba[eq_int_req_num]) m_pended++;
                    m_pba[eq_int_req_num] = 1'b1;
                end else begin
                    m_eq_pending = 1;
                    m_eq_num = int'(eq_int_req_num);
                end
            end
        end
    end

    // Table responder: returns tbl[num] the cycle after a lookup handshake
    initial begin
        int n;
        forever begin
            @(negedge clk);
            if (rst_n && tbl_req_valid && tbl_req_ready) begin
                n = int'(tbl_req_num);
                @(posedge clk); #1;
                tbl_rsp_valid = 1'b1;
                tbl_rsp_data  = tbl[n];
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (tbl_rsp_ready || !rst_n) break;
                end
                @(posedge clk); #1;
                tbl_rsp_valid = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (all return at rising edge + 1)
    // ------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int n);
        bit ok;
        ok = 0;
        eq_int_req_valid = 1'b1;
        eq_int_req_num   = NL'(n);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (eq_int_req_ready) ok = 1;
            @(posedge clk); #1;
            if (ok) break;
        end
        eq_int_req_valid = 1'b0;
        if (!ok) chk("req_accept_timeout", ok, 1'b1);
    endtask

    task automatic wait_writes(input int target, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (n_writes >= target) break;
            tick(1);
        end
        chk("write_count", n_writes, target);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_eq_ready"}, eq_int_req_ready, 1'b0);
        chk({tag, "_tbl_req_valid"}, tbl_req_valid, 1'b0);
        chk({tag, "_tbl_req_num"}, tbl_req_num, '0);
        chk({tag, "_tbl_rsp_ready"}, tbl_rsp_ready, 1'b0);
        chk({tag, "_wr_valid"}, msix_wr_valid, 1'b0);
        chk({tag, "_wr_addr"}, msix_wr_addr, '0);
        chk({tag, "_wr_data"}, msix_wr_data, '0);
        chk({tag, "_pba"}, pba, '0);
        chk({tag, "_addr_err"}, addr_err, 1'b0);
    endtask

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed tests
    // ------------------------------------------------------------------
    initial begin
        int w0, lk0, t0, t1;
        bit seen;

        for (int i = 0; i < NV; i++)
            tbl[i] = {32'h0, 32'h100 + 32'(i), 32'h1, 32'hFEE0_0000 + 32'(i * 16)};
        tbl[5]  = {32'h0, 32'h0000_00AB, 32'h1, 32'hFEE0_0000};
        tbl[3]  = {32'h1, 32'h0000_0333, 32'h2, 32'hFEE0_0300};
        tbl[11] = {32'h0, 32'h0000_0BBB, 32'h1, 32'hFEE0_0002};

        // Reset state
        #2;
        chk_all_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_reset", eq_int_req_ready, 1'b1);
        cfg_msix_en = 1'b1;

        // 1: plain delivery of vector 5
        send_req(5);
        chk("t1_lookup_cycle1", tbl_req_valid, 1'b1);
        chk("t1_lookup_num", tbl_req_num, 6'd5);
        wait_writes(1, 30);
        chk("t1_addr", last_wr_addr, 64'h0000_0001_FEE0_0000);
        chk("t1_data", last_wr_data, 32'h0000_00AB);
        chk("t1_wr_latency", wr_first_cyc - rsp_cyc, 1);
        chk("t1_pba", pba, '0);

        // 2: masked entry parks vector 3, rescan delivers it after unmask
        w0 = n_writes;
        send_req(3);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pba[3]) begin seen = 1; break; end
        end
        t0 = cyc;
        chk("t2_pba_set", pba, 64'h8);
        chk("t2_no_write", n_writes, w0);
        tbl[3][96] = 1'b0;
        seen = 0;
        for (int k = 0; k < 4 * RI; k++) begin
            if (tbl_req_valid) begin seen = 1; break; end
            @(negedge clk);
        end
        t1 = cyc;
        chk("t2_retry_seen", seen, 1'b1);
        chk("t2_retry_delay", t1 - t0, RI);
        chk("t2_retry_num", tbl_req_num, 6'd3);
        @(posedge clk); #1;
        wait_writes(w0 + 1, 30);
        chk("t2_data", last_wr_data, 32'h0000_0333);
        chk("t2_pba_clear", pba, '0);

        // 3: function mask parks 7 and 2; unmask replays lowest first
        cfg_func_mask = 1'b1;
        lk0 = n_lookups;
        w0  = n_writes;
        send_req(7);
        send_req(2);
        tick(2);
        chk("t3_pba", pba, 64'h84);
        tick(RI + 5);
        chk("t3_no_lookups", n_lookups, lk0);
        cfg_func_mask = 1'b0;
        wait_writes(w0 + 2, 4 * RI + 40);
        chk("t3_first_retry", lk_hist[lk_hist.size() - 2], 2);
        chk("t3_second_retry", lk_hist[lk_hist.size() - 1], 7);
        chk("t3_pba_clear", pba, '0);

        // 4: MSI-X disabled drops the request
        cfg_msix_en = 1'b0;
        lk0 = n_lookups;
        @(negedge clk);
        chk("t4_ready", eq_int_req_ready, 1'b1);
        @(posedge clk); #1;
        send_req(9);
        tick(5);
        chk("t4_no_lookup", n_lookups, lk0);
        chk("t4_pba", pba, '0);
`ifdef RDMA_INT_MSG_STAT_EN
        chk("t4_stat_dropped", stat_dropped, 32'd1);
`endif
        cfg_msix_en = 1'b1;

        // 5: misaligned address sets the sticky error; later request writes
        w0 = n_writes;
        send_req(11);
        tick(6);
        chk("t5_addr_err", addr_err, 1'b1);
        chk("t5_no_write", n_writes, w0);
        send_req(5);
        wait_writes(w0 + 1, 30);
        chk("t5_addr_err_sticky", addr_err, 1'b1);

        // 6: reset while stalled in the write phase
        msix_wr_ready = 1'b0;
        send_req(12);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            if (msix_wr_valid) begin seen = 1; break; end
            tick(1);
        end
        chk("t6_wr_pending", seen, 1'b1);
        tick(10);
        chk("t6_wr_held", msix_wr_valid, 1'b1);
        chk("t6_wr_addr_held", msix_wr_addr, 64'h0000_0001_FEE0_00C0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("t6_reset");
        w0 = n_writes;
        chk("t6_no_write", n_writes, w0);
        tick(2);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        msix_wr_ready = 1'b1;
        w0 = n_writes;
        send_req(5);
        wait_writes(w0 + 1, 30);
        chk("t6_after_addr", last_wr_addr, 64'h0000_0001_FEE0_0000);
        chk("t6_after_pba", pba, '0);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
